uart_rx_loader: RTL and testbench

UART_RX_LOADER -- requirements
Module: uart_rx_loader

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_byte.sv | 143 ++++++++++++++
 rtl/uart_rx_loader.sv | 85 ++++++++
 tb/tb_uart_rx_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART receive loader shared types, frame constants and bit-period math.
// Build with UART_RX_PARITY_EN defined to add an even-parity bit per frame.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int WORD_BYTES = 4;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;
`endif

  function automatic int div_of(int clk_freq, int baud);
    return clk_freq / baud;
  endfunction

  function automatic int half_of(int clk_freq, int baud);
    return div_of(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Serial byte receiver: line synchronizer, baud counter and frame FSM.
// UART_RX_PARITY_EN adds an even-parity state between data and stop.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       clear,
  output logic       byte_valid,
  output logic       byte_err,
  output logic [7:0] byte_data,
  output logic       busy
);

  localparam int DIV  = div_of(CLK_FREQ, BAUD);
  localparam int HALF = half_of(CLK_FREQ, BAUD);
  localparam int CW   = $clog2(DIV);

  logic          s1, s2, s3;
  logic          fall;
  rx_state_e     state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bits, bits_d;
  logic [7:0]    shreg, shreg_d;
  logic          tick;
`ifdef UART_RX_PARITY_EN
  logic          par_err, par_err_d;
`else
  logic          par_err;
  assign par_err = 1'b0;
`endif

  // s3 is the previous synchronized level, used only for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;
  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      bits  <= '0;
      shreg <= '0;
`ifdef UART_RX_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      bits  <= bits_d;
      shreg <= shreg_d;
`ifdef UART_RX_PARITY_EN
      par_err <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt + 1'b1;
    bits_d     = bits;
    shreg_d    = shreg;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d  = par_err;
`endif
    unique case (state)
      IDLE: begin
        cnt_d  = '0;
        bits_d = '0;
`ifdef UART_RX_PARITY_EN
        par_err_d = 1'b0;
`endif
        if (fall) state_d = START;
      end
      START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_d   = '0;
          state_d = s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shreg_d = {s2, shreg[7:1]};
          bits_d  = bits + 1'b1;
          if (bits == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          cnt_d     = '0;
          par_err_d = (s2 != ^shreg);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          cnt_d      = '0;
          state_d    = IDLE;
          byte_valid = s2 & ~par_err;
          byte_err   = ~s2 | par_err;
        end
      end
      default: state_d = IDLE;
    endcase
    // a clear aborts any frame, including one completing this cycle
    if (clear) begin
      state_d    = IDLE;
      cnt_d      = '0;
      byte_valid = 1'b0;
      byte_err   = 1'b0;
    end
  end

  assign byte_data = shreg;
  assign busy      = (state != IDLE);

endmodule

// File: rtl/uart_rx_loader.sv
// Packs received UART bytes little-endian into 32-bit words and writes them
// to sequential addresses. UART_RX_PARITY_EN enables per-frame even parity.
module uart_rx_loader
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 115200,
  parameter int WORDS    = 16
) (
  input  logic                     clk_sys_i,
  input  logic                     rstn_i,
  input  logic                     rx_i,
  input  logic                     clear_i,
  output logic                     wr_en_o,
  output logic [$clog2(WORDS)-1:0] wr_addr_o,
  output logic [31:0]              wr_data_o,
  output logic                     load_done_o,
  output logic                     frame_err_o,
  output logic                     busy_o
);

  localparam int AW = $clog2(WORDS);

  logic          byte_valid;
  logic          byte_err;
  logic [7:0]    byte_data;
  logic [1:0]    idx;
  logic [23:0]   partial;
  logic [AW-1:0] addr;
  logic          last;

  uart_rx_byte #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_byte (
    .clk       (clk_sys_i),
    .rst_n     (rstn_i),
    .rx        (rx_i),
    .clear     (clear_i),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .byte_data (byte_data),
    .busy      (busy_o)
  );

  assign last = (addr == AW'(WORDS - 1));

  always_ff @(posedge clk_sys_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idx         <= '0;
      partial     <= '0;
      addr        <= '0;
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      load_done_o <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      wr_en_o <= 1'b0;
      if (clear_i) begin
        idx         <= '0;
        addr        <= '0;
        wr_addr_o   <= '0;
        load_done_o <= 1'b0;
        frame_err_o <= 1'b0;
      end else begin
        if (byte_err) frame_err_o <= 1'b1;
        if (byte_valid && !load_done_o) begin
          idx <= idx + 1'b1;
          if (idx == 2'(WORD_BYTES - 1)) begin
            wr_en_o     <= 1'b1;
            wr_data_o   <= {byte_data, partial};
            wr_addr_o   <= addr;
            addr        <= last ? '0 : addr + 1'b1;
            load_done_o <= last;
          end else begin
            // oldest byte shifts down so three bytes land as {b2,b1,b0}
            partial <= {byte_data, partial[23:8]};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench for uart_rx_loader at default parameters (86-cycle bit).
// Define UART_RX_PARITY_EN for both RTL and bench to exercise parity.
module tb_uart_rx_loader;

  localparam int DIV = 86;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic        rx    = 1'b1;
  logic        clear = 1'b0;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        load_done;
  logic        frame_err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0]  addr_q[$];
  logic [31:0] data_q[$];

  uart_rx_loader dut (
    .clk_sys_i  (clk),
    .rstn_i     (rstn),
    .rx_i       (rx),
    .clear_i    (clear),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .load_done_o(load_done),
    .frame_err_o(frame_err),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      addr_q.push_back(wr_addr);
      data_q.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bz) rx = 1'b1;
`endif
    drive_bit(stop);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1, ^d);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  function automatic logic [31:0] word_of(input int w);
    if (w == 0) return 32'h1234_5678;
    return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
  endfunction

  function automatic logic [7:0] byte_of(input int k);
    logic [31:0] wv;
    wv = word_of(k / 4);
    return wv[8*(k%4) +: 8];
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_data", wr_data, 0);
    check("rst_done", 32'(load_done), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_busy", 32'(busy), 0);
    rstn = 1'b1;
    repeat (20) @(negedge clk);

    // full load: first word is 0x12345678, then a pattern, back to back
    for (int k = 0; k < 64; k++) send_byte(byte_of(k));
    repeat (4) @(negedge clk);
    check("load_nwr", 32'(addr_q.size()), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < addr_q.size()) begin
        check($sformatf("load_addr%0d", i), 32'(addr_q[i]), 32'(i));
        check($sformatf("load_data%0d", i), data_q[i], word_of(i));
      end else begin
        check($sformatf("load_miss%0d", i), 0, 1);
      end
    end
    check("load_done", 32'(load_done), 1);
    check("load_ferr", 32'(frame_err), 0);
    send_byte(8'hEE);
    repeat (4) @(negedge clk);
    check("extra_nwr", 32'(addr_q.size()), 16);
    check("extra_done", 32'(load_done), 1);

    pulse_clear();
    check("clr_done", 32'(load_done), 0);
    check("clr_addr", 32'(wr_addr), 0);
    addr_q.delete();
    data_q.delete();

    // framing error on the second byte; it is dropped
    send_byte(8'h11);
    send_frame(8'h22, 1'b0, ^8'h22);
    drive_bit(1'b1);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    repeat (4) @(negedge clk);
    check("ferr_flag", 32'(frame_err), 1);
    check("ferr_nwr", 32'(addr_q.size()), 1);
    if (addr_q.size() > 0) begin
      check("ferr_addr", 32'(addr_q[0]), 0);
      check("ferr_data", data_q[0], 32'h5544_3311);
    end

    // clear during data bit 4 with a partial word pending at address 1
    send_byte(8'h66);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_busy_pre", 32'(busy), 1);
    pulse_clear();
    check("mid_busy", 32'(busy), 0);
    check("mid_addr", 32'(wr_addr), 0);
    check("mid_ferr", 32'(frame_err), 0);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    addr_q.delete();
    data_q.delete();
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    repeat (4) @(negedge clk);
    check("mid_nwr", 32'(addr_q.size()), 1);
    if (addr_q.size() > 0) begin
      check("mid_waddr", 32'(addr_q[0]), 0);
      check("mid_wdata", data_q[0], 32'hD4C3_B2A1);
    end

    // 20-cycle low glitch on an idle line
    addr_q.delete();
    data_q.delete();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_in", 32'(busy), 1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (150) @(negedge clk);
    check("glitch_busy", 32'(busy), 0);
    check("glitch_ferr", 32'(frame_err), 0);
    check("glitch_nwr", 32'(addr_q.size()), 0);

    // reset mid-frame
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rstn = 1'b0;
    @(negedge clk);
    check("rstm_busy", 32'(busy), 0);
    check("rstm_data", wr_data, 0);
    check("rstm_addr", 32'(wr_addr), 0);
    repeat (3) @(negedge clk);
    rx   = 1'b1;
    rstn = 1'b1;
    repeat (1000) @(negedge clk);
    check("rstm_nwr", 32'(addr_q.size()), 0);
    check("rstm_busy2", 32'(busy), 0);

`ifdef UART_RX_PARITY_EN
    pulse_clear();
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("par_bad", 32'(frame_err), 1);
    pulse_clear();
    addr_q.delete();
    data_q.delete();
    send_frame(8'h07, 1'b1, 1'b1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    repeat (4) @(negedge clk);
    check("par_ok", 32'(frame_err), 0);
    check("par_nwr", 32'(addr_q.size()), 1);
    if (data_q.size() > 0) check("par_data", data_q[0], 32'h0302_0107);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
